pc_next_ctrl: RTL and testbench

- Producer side of the PC register interface. Each cycle it computes the next-PC value and the PC stall strobe.
- Also generates the matching pipeline-register controls: IF/ID stall, IF/ID flush, ID/EX bubble, and a full freeze while a data-memory access is outstanding.
- Sits beside the ID stage. Its outputs drive the PC register's next-PC and stall inputs, and the pipeline registers.

---
 rtl/pc_next_ctrl.sv | 126 ++++++++++++
 tb/tb_pc_next_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_ctrl.sv
// Next-PC and pipeline hazard control: selects the next PC and drives stall, flush,
// bubble and freeze strobes from load-use hazards, branches/jumps and data-memory waits.
module pc_next_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      pc_cur_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic [4:0]       if_id_rs_i,
  input  logic [4:0]       if_id_rt_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic [31:0]      pc_next_o,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             mem_err_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_mem_err;
  logic              w_lu;
  logic              w_mf;

  // Hazard detection
  always_comb begin
    w_lu = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
           ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));
    w_mf = (r_state == MEM_WAIT) ||
           ((r_state == RUN) && mem_req_i && !mem_ack_i);
  end

  // Next state and prioritised control outputs
  always_comb begin
    w_state_next   = r_state;
    pc_next_o      = pc_cur_i;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pipe_freeze_o  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_i) w_state_next = RUN;
      end
      RUN: begin
        if (!start_i)                    w_state_next = IDLE;
        else if (mem_req_i && !mem_ack_i) w_state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_ack_i) w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase

    if (r_state == IDLE) begin
      pc_stall_o = 1'b1;
    end else if (w_mf) begin
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
      pipe_freeze_o = 1'b1;
    end else if (w_lu) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (jump_i) begin
      pc_next_o     = jump_target_i;
      if_id_flush_o = 1'b1;
    end else if (branch_i) begin
      pc_next_o     = branch_target_i;
      if_id_flush_o = 1'b1;
    end else begin
      pc_next_o = pc_cur_i + 32'd4;
    end
  end

  assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

  // State, stall statistics and memory-timeout tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_stall_cnt <= '0;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (pc_stall_o && (r_state != IDLE) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((r_state == RUN) && (w_state_next == MEM_WAIT)) begin
        r_wait_cnt <= '0;
      end else if ((r_state == MEM_WAIT) && (r_wait_cnt != WAIT_W'(MEM_TIMEOUT))) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == WAIT_W'(MEM_TIMEOUT)) r_mem_err <= 1'b1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign mem_err_o   = r_mem_err;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Testbench for pc_next_ctrl: directed scenarios then randomized traffic, all checked
// against a cycle-level behavioural model of the next-PC/hazard rules.
module tb_pc_next_ctrl;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [31:0]      pc_cur_i;
  logic             branch_i;
  logic [31:0]      branch_target_i;
  logic             jump_i;
  logic [31:0]      jump_target_i;
  logic             id_ex_memread_i;
  logic [4:0]       id_ex_rt_i;
  logic [4:0]       if_id_rs_i;
  logic [4:0]       if_id_rt_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic [31:0]      pc_next_o;
  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             if_id_flush_o;
  logic             id_ex_bubble_o;
  logic             pipe_freeze_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             mem_err_o;

  pc_next_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_cur_i(pc_cur_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .id_ex_memread_i(id_ex_memread_i), .id_ex_rt_i(id_ex_rt_i),
    .if_id_rs_i(if_id_rs_i), .if_id_rt_i(if_id_rt_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_next_o(pc_next_o), .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
    .pipe_freeze_o(pipe_freeze_o), .stall_cnt_o(stall_cnt_o), .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model: running/waiting flags, stall count, MEM_WAIT cycle count, sticky error
  bit running, waiting, m_err;
  int m_cnt, m_waits;
  bit [31:0] e_pc;
  bit e_pcs, e_ifs, e_fl, e_bub, e_frz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    running = 0; waiting = 0; m_err = 0; m_cnt = 0; m_waits = 0;
  endtask

  task automatic model_outputs();
    bit lu, mf;
    lu = id_ex_memread_i && id_ex_rt_i != 0 &&
         (id_ex_rt_i == if_id_rs_i || id_ex_rt_i == if_id_rt_i);
    mf = waiting || (running && mem_req_i && !mem_ack_i);
    e_pc = pc_cur_i; e_pcs = 0; e_ifs = 0; e_fl = 0; e_bub = 0; e_frz = 0;
    if (!running && !waiting)  e_pcs = 1;
    else if (mf)               begin e_pcs = 1; e_ifs = 1; e_frz = 1; end
    else if (lu)               begin e_pcs = 1; e_ifs = 1; e_bub = 1; end
    else if (jump_i)           begin e_pc = jump_target_i; e_fl = 1; end
    else if (branch_i)         begin e_pc = branch_target_i; e_fl = 1; end
    else                       e_pc = pc_cur_i + 32'd4;
  endtask

  task automatic model_clock();
    if ((running || waiting) && e_pcs && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    if (waiting) begin
      m_waits++;
      if (m_waits >= TIMEOUT) m_err = 1;
      if (mem_ack_i) begin waiting = 0; running = 1; end
    end else if (running) begin
      if (!start_i) running = 0;
      else if (mem_req_i && !mem_ack_i) begin running = 0; waiting = 1; m_waits = 0; end
    end else if (start_i) running = 1;
  endtask

  // Compare every output against the model at the falling edge
  task automatic settle();
    if (rst_i) model_reset();
    @(negedge clk_i);
    model_outputs();
    check("pc_next", pc_next_o, e_pc);
    check("pc_stall", 32'(pc_stall_o), 32'(e_pcs));
    check("if_id_stall", 32'(if_id_stall_o), 32'(e_ifs));
    check("if_id_flush", 32'(if_id_flush_o), 32'(e_fl));
    check("id_ex_bubble", 32'(id_ex_bubble_o), 32'(e_bub));
    check("pipe_freeze", 32'(pipe_freeze_o), 32'(e_frz));
    check("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
    check("mem_err", 32'(mem_err_o), 32'(m_err));
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (!rst_i) model_clock();
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic quiet();
    branch_i = 0; jump_i = 0; id_ex_memread_i = 0; id_ex_rt_i = 0;
    if_id_rs_i = 0; if_id_rt_i = 0; mem_req_i = 0; mem_ack_i = 0;
    branch_target_i = 32'h200; jump_target_i = 32'h300;
  endtask

  task automatic do_reset();
    rst_i = 1; tick(); rst_i = 0;
  endtask

  initial begin
    rst_i = 1; start_i = 0; pc_cur_i = 32'h100; quiet();
    model_reset();

    // Reset state
    settle();
    check("rst_cnt", 32'(stall_cnt_o), 32'd0);
    check("rst_pcstall", 32'(pc_stall_o), 32'd1);
    advance();
    rst_i = 0; start_i = 1;
    tick();                                   // IDLE -> RUN
    settle(); check("seq_pc", pc_next_o, 32'h104); advance();
    pc_cur_i = 32'hFFFF_FFFC;
    settle(); check("wrap_pc", pc_next_o, 32'h0); advance();

    // Load-use hazard, then rt=0 suppresses it
    pc_cur_i = 32'h100; id_ex_memread_i = 1; id_ex_rt_i = 5; if_id_rs_i = 5;
    settle(); check("lu_bubble", 32'(id_ex_bubble_o), 32'd1);
    check("lu_cnt0", 32'(stall_cnt_o), 32'd0); advance();
    settle(); check("lu_cnt1", 32'(stall_cnt_o), 32'd1); advance();
    id_ex_rt_i = 0; if_id_rs_i = 0;
    settle(); check("lu_rt0", 32'(pc_stall_o), 32'd0); advance();
    quiet();

    // Jump beats branch, then branch alone
    branch_i = 1; jump_i = 1;
    settle(); check("jmp_pc", pc_next_o, 32'h300); advance();
    jump_i = 0;
    settle(); check("br_pc", pc_next_o, 32'h200); advance();

    // Memory freeze with a branch held across it
    quiet(); do_reset(); tick();
    branch_i = 1; mem_req_i = 1;
    tick(); mem_req_i = 0; tick(); tick();
    mem_ack_i = 1;
    settle(); check("frz_last", 32'(pipe_freeze_o), 32'd1); advance();
    mem_ack_i = 0;
    settle(); check("frz_flush", 32'(if_id_flush_o), 32'd1);
    check("frz_cnt", 32'(stall_cnt_o), 32'd4); advance();
    branch_i = 0; mem_req_i = 1; mem_ack_i = 1;
    settle(); check("ack_same", 32'(pipe_freeze_o), 32'd0); advance();

    // Timeout, sticky error, reset mid-wait
    mem_ack_i = 0;
    for (int i = 0; i < 6; i++) tick();
    mem_req_i = 0; mem_ack_i = 1;
    settle(); check("to_err", 32'(mem_err_o), 32'd1); advance();
    mem_ack_i = 0;
    settle(); check("to_sticky", 32'(mem_err_o), 32'd1); advance();
    mem_req_i = 1; tick(); tick(); mem_req_i = 0;
    rst_i = 1;
    settle(); check("rst_err", 32'(mem_err_o), 32'd0);
    check("rst_cnt2", 32'(stall_cnt_o), 32'd0); advance();
    rst_i = 0;

    // start low holds PC; drop start during MEM_WAIT
    start_i = 0; tick();
    settle(); check("idle_pc", pc_next_o, pc_cur_i); advance();
    start_i = 1; tick();
    mem_req_i = 1; tick(); mem_req_i = 0; start_i = 0; tick();
    mem_ack_i = 1; tick(); mem_ack_i = 0;
    settle(); check("drop_run", 32'(pc_stall_o), 32'd0); advance();
    settle(); check("drop_idle", 32'(pc_stall_o), 32'd1); advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_i           = ($urandom_range(0, 149) == 0);
      start_i         = ($urandom_range(0, 19) != 0);
      pc_cur_i        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      branch_i        = ($urandom_range(0, 3) == 0);
      jump_i          = ($urandom_range(0, 4) == 0);
      branch_target_i = $urandom;
      jump_target_i   = $urandom;
      id_ex_memread_i = $urandom_range(0, 1) == 1;
      id_ex_rt_i      = 5'($urandom_range(0, 3));
      if_id_rs_i      = 5'($urandom_range(0, 3));
      if_id_rt_i      = 5'($urandom_range(0, 3));
      mem_req_i       = ($urandom_range(0, 3) == 0);
      mem_ack_i       = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
